// File: rtl/a2d_rr_intf.sv
// Round-robin SPI master for the ADC128S. Each nxt runs an address frame and then a
// read frame, and files the 12-bit result into the register for that channel.
module a2d_rr_intf #(
  parameter logic [2:0] CH_LFT   = 3'd0,
  parameter logic [2:0] CH_RGHT  = 3'd4,
  parameter logic [2:0] CH_STEER = 3'd5,
  parameter logic [2:0] CH_BATT  = 3'd6
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        nxt,
  output logic [11:0] lft_ld,
  output logic [11:0] rght_ld,
  output logic [11:0] steer_pot,
  output logic [11:0] batt,
  output logic        cnv_cmplt,
  output logic        SS_n,
  output logic        SCLK,
  output logic        MOSI,
  input  logic        MISO
);

  // Latency: nxt is sampled on edge 0. Frame 1 holds SS_n low for 521 clks and ends
  // on edge 521. The gap edge 522 starts frame 2, which ends on edge 1043, and
  // cnv_cmplt rises there. That is 1 + 521 + 1 + 521 = 1044 rising edges,
  // counting edge 0.
  typedef enum logic [1:0] {IDLE = 2'd0, XFER1 = 2'd1, GAP = 2'd2, XFER2 = 2'd3} state_t;

  localparam logic [4:0] DIV_LOAD   = 5'b10111;
  localparam logic [4:0] DIV_SAMPLE = 5'b01111;
  localparam logic [4:0] DIV_FALL   = 5'b11111;
  localparam logic [4:0] LAST_BIT   = 5'd16;

  state_t      state_r;
  logic [4:0]  sclk_div_r;
  logic [4:0]  bit_cnt_r;
  logic [15:0] shift_r;
  logic        shadow_r;
  logic        active_r;
  logic [1:0]  rr_r;

  logic        sample_s;
  logic        fall_s;
  logic        shift_en_s;
  logic        done_s;
  logic [15:0] shift_nxt_s;
  logic [2:0]  ch_s;

  assign SCLK = sclk_div_r[4];
  assign MOSI = shift_r[15];

  // Divider decode and channel select for the current round-robin slot
  always_comb begin
    sample_s    = active_r && (sclk_div_r == DIV_SAMPLE);
    fall_s      = active_r && (sclk_div_r == DIV_FALL);
    shift_en_s  = fall_s && (bit_cnt_r != 5'd0);
    done_s      = fall_s && (bit_cnt_r == LAST_BIT);
    shift_nxt_s = {shift_r[14:0], shadow_r};
    case (rr_r)
      2'd0:    ch_s = CH_LFT;
      2'd1:    ch_s = CH_RGHT;
      2'd2:    ch_s = CH_STEER;
      2'd3:    ch_s = CH_BATT;
      default: ch_s = CH_LFT;
    endcase
  end

  // SPI engine, conversion sequencer and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      sclk_div_r <= DIV_FALL;
      bit_cnt_r  <= 5'd0;
      shift_r    <= 16'h0000;
      shadow_r   <= 1'b0;
      active_r   <= 1'b0;
      rr_r       <= 2'd0;
      SS_n       <= 1'b1;
      cnv_cmplt  <= 1'b0;
      lft_ld     <= 12'h000;
      rght_ld    <= 12'h000;
      steer_pot  <= 12'h000;
      batt       <= 12'h000;
    end else begin
      cnv_cmplt <= 1'b0;
      // The divider freezes at 5'b11111 on the final bit, so SCLK parks high
      if (active_r && !done_s) sclk_div_r <= sclk_div_r + 5'd1;
      if (sample_s) begin
        shadow_r  <= MISO;
        bit_cnt_r <= bit_cnt_r + 5'd1;
      end
      if (shift_en_s) shift_r <= shift_nxt_s;
      case (state_r)
        IDLE: begin
          // cnv_cmplt marks the cycle the machine is still leaving XFER2
          if (nxt && !cnv_cmplt) begin
            shift_r    <= {2'b00, ch_s, 11'h000};
            sclk_div_r <= DIV_LOAD;
            bit_cnt_r  <= 5'd0;
            active_r   <= 1'b1;
            SS_n       <= 1'b0;
            state_r    <= XFER1;
          end
        end
        XFER1: begin
          if (done_s) begin
            SS_n     <= 1'b1;
            active_r <= 1'b0;
            state_r  <= GAP;
          end
        end
        GAP: begin
          shift_r    <= 16'h0000;
          sclk_div_r <= DIV_LOAD;
          bit_cnt_r  <= 5'd0;
          active_r   <= 1'b1;
          SS_n       <= 1'b0;
          state_r    <= XFER2;
        end
        XFER2: begin
          if (done_s) begin
            SS_n      <= 1'b1;
            active_r  <= 1'b0;
            cnv_cmplt <= 1'b1;
            rr_r      <= rr_r + 2'd1;
            state_r   <= IDLE;
            case (rr_r)
              2'd0:    lft_ld    <= shift_nxt_s[11:0];
              2'd1:    rght_ld   <= shift_nxt_s[11:0];
              2'd2:    steer_pot <= shift_nxt_s[11:0];
              2'd3:    batt      <= shift_nxt_s[11:0];
              default: lft_ld    <= lft_ld;
            endcase
          end
        end
        default: begin
          SS_n     <= 1'b1;
          active_r <= 1'b0;
          state_r  <= IDLE;
        end
      endcase
    end
  end

endmodule
